// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: controller state encoding and shared register constants
package pipeline_hazard_ctrl_pkg;
    typedef enum logic [1:0] {
        CTRL_RUN      = 2'd0,
        CTRL_FLUSH    = 2'd1,
        CTRL_BUSY     = 2'd2,
        CTRL_EXT_HOLD = 2'd3
    } ctrl_state_e;
    localparam logic [4:0] ZERO_REG = 5'b0;
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard requests from the pipeline and hold/flush controls back to it
interface pipeline_hazard_ctrl_if;
    logic        ex_jump_flag_in;
    logic [31:0] ex_jump_addr_in;
    logic        ex_load_flag_in;
    logic [4:0]  ex_write_addr_in;
    logic        ex_busy_in;
    logic [4:0]  id_reg1_addr_in;
    logic [4:0]  id_reg2_addr_in;
    logic        id_reg1_re_in;
    logic        id_reg2_re_in;
    logic        ext_hold_req_in;
    logic        ctrl_jump_flag_out;
    logic [31:0] ctrl_jump_addr_out;
    logic        ctrl_pc_hold_out;
    logic        ctrl_ifd_hold_out;
    logic        ctrl_ifd_flush_out;
    logic        ctrl_idd_hold_out;
    logic        ctrl_idd_flush_out;
    logic [1:0]  ctrl_state_out;
    logic [31:0] ctrl_stall_cnt_out;
    modport master (
        output ex_jump_flag_in, ex_jump_addr_in, ex_load_flag_in, ex_write_addr_in, ex_busy_in,
               id_reg1_addr_in, id_reg2_addr_in, id_reg1_re_in, id_reg2_re_in, ext_hold_req_in,
        input  ctrl_jump_flag_out, ctrl_jump_addr_out, ctrl_pc_hold_out, ctrl_ifd_hold_out,
               ctrl_ifd_flush_out, ctrl_idd_hold_out, ctrl_idd_flush_out, ctrl_state_out,
               ctrl_stall_cnt_out
    );
    modport slave (
        input  ex_jump_flag_in, ex_jump_addr_in, ex_load_flag_in, ex_write_addr_in, ex_busy_in,
               id_reg1_addr_in, id_reg2_addr_in, id_reg1_re_in, id_reg2_re_in, ext_hold_req_in,
        output ctrl_jump_flag_out, ctrl_jump_addr_out, ctrl_pc_hold_out, ctrl_ifd_hold_out,
               ctrl_ifd_flush_out, ctrl_idd_hold_out, ctrl_idd_flush_out, ctrl_state_out,
               ctrl_stall_cnt_out
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// hazard_detect: load-use dependency between the load in EX and the source registers read in ID
module hazard_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic       i_ex_load,
    input  logic [4:0] i_ex_rd,
    input  logic [4:0] i_rs1,
    input  logic [4:0] i_rs2,
    input  logic       i_re1,
    input  logic       i_re2,
    output logic       o_load_use
);
    assign o_load_use = i_ex_load && (i_ex_rd != ZERO_REG) &&
                        ((i_re1 && (i_rs1 == i_ex_rd)) || (i_re2 && (i_rs2 == i_ex_rd)));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencing FSM for the PC, IF/ID and ID/EX registers
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int FLUSH_DEPTH = 2
) (
    input logic                 clk,
    input logic                 rst,
    pipeline_hazard_ctrl_if.slave io_bus
);
    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_DEPTH - 1);
    ctrl_state_e r_state, w_next;
    logic [2:0]  r_flush_cnt, w_flush_cnt_next;
    logic [31:0] r_stall_cnt;
    logic        w_load_use, w_run, w_jump, w_rest, w_hold_st, w_flush_st;
    hazard_detect u_hazard_detect (
        .i_ex_load  (io_bus.ex_load_flag_in),
        .i_ex_rd    (io_bus.ex_write_addr_in),
        .i_rs1      (io_bus.id_reg1_addr_in),
        .i_rs2      (io_bus.id_reg2_addr_in),
        .i_re1      (io_bus.id_reg1_re_in),
        .i_re2      (io_bus.id_reg2_re_in),
        .o_load_use (w_load_use)
    );
    // Cycles in which RUN priorities apply, including the Mealy exits from BUSY/EXT_HOLD
    assign w_run = (r_state == CTRL_RUN) ||
                   (r_state == CTRL_BUSY && !io_bus.ex_busy_in) ||
                   (r_state == CTRL_EXT_HOLD && (io_bus.ex_jump_flag_in || !io_bus.ext_hold_req_in));
    assign w_jump     = !rst && w_run && io_bus.ex_jump_flag_in;
    assign w_rest     = !rst && w_run && !io_bus.ex_jump_flag_in;
    assign w_hold_st  = !rst && !w_run && (r_state == CTRL_BUSY || r_state == CTRL_EXT_HOLD);
    assign w_flush_st = !rst && (r_state == CTRL_FLUSH);
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= CTRL_RUN;
            r_flush_cnt <= 3'd0;
            r_stall_cnt <= 32'd0;
        end else begin
            r_state     <= w_next;
            r_flush_cnt <= w_flush_cnt_next;
            r_stall_cnt <= r_stall_cnt + {31'd0, io_bus.ctrl_pc_hold_out};
        end
    end
    always_comb begin
        w_next           = r_state;
        w_flush_cnt_next = r_flush_cnt;
        if (r_state == CTRL_FLUSH) begin
            w_flush_cnt_next = r_flush_cnt - 3'd1;
            w_next           = (r_flush_cnt == 3'd1) ? CTRL_RUN : CTRL_FLUSH;
        end else if (w_run) begin
            w_flush_cnt_next = io_bus.ex_jump_flag_in ? FLUSH_INIT : r_flush_cnt;
            w_next = io_bus.ex_jump_flag_in ? ((FLUSH_DEPTH > 1) ? CTRL_FLUSH : CTRL_RUN) :
                     io_bus.ex_busy_in      ? CTRL_BUSY :
                     w_load_use             ? CTRL_RUN :
                     io_bus.ext_hold_req_in ? CTRL_EXT_HOLD : CTRL_RUN;
        end
    end
    always_comb begin
        io_bus.ctrl_jump_flag_out = w_jump;
        io_bus.ctrl_jump_addr_out = w_jump ? io_bus.ex_jump_addr_in : 32'd0;
        io_bus.ctrl_pc_hold_out   = w_hold_st ||
                                    (w_rest && (io_bus.ex_busy_in || w_load_use || io_bus.ext_hold_req_in));
        io_bus.ctrl_ifd_hold_out  = io_bus.ctrl_pc_hold_out;
        io_bus.ctrl_ifd_flush_out = w_jump || w_flush_st;
        io_bus.ctrl_idd_flush_out = w_jump || w_flush_st || (w_rest && !io_bus.ex_busy_in && w_load_use);
        io_bus.ctrl_idd_hold_out  = w_hold_st ||
                                    (w_rest && (io_bus.ex_busy_in || (!w_load_use && io_bus.ext_hold_req_in)));
        io_bus.ctrl_state_out     = rst ? 2'd0 : r_state;
        io_bus.ctrl_stall_cnt_out = rst ? 32'd0 : r_stall_cnt;
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scoreboard bench with a behavioural model of the hazard controller
module tb_pipeline_hazard_ctrl;
    typedef struct packed {
        logic        rst;
        logic        jump;
        logic [31:0] addr;
        logic        load;
        logic [4:0]  rd;
        logic        busy;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        re1;
        logic        re2;
        logic        ext;
    } stim_t;
    typedef struct packed {
        logic        jf;
        logic [31:0] ja;
        logic        pc_hold;
        logic        if_hold;
        logic        if_flush;
        logic        id_hold;
        logic        id_flush;
        logic [1:0]  st;
        logic [31:0] sc;
    } obs_t;
    localparam int DEPTH = 2;
    logic clk = 1'b0;
    logic rst;
    pipeline_hazard_ctrl_if bus ();
    pipeline_hazard_ctrl #(.FLUSH_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .io_bus(bus));
    always #5 clk = ~clk;
    obs_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;
    string phase = "reset";
    int          m_mode = 0;
    int          m_left = 0;
    logic [31:0] m_stalls = 32'd0;
    task automatic apply(input stim_t s);
        rst                  = s.rst;
        bus.ex_jump_flag_in  = s.jump;
        bus.ex_jump_addr_in  = s.addr;
        bus.ex_load_flag_in  = s.load;
        bus.ex_write_addr_in = s.rd;
        bus.ex_busy_in       = s.busy;
        bus.id_reg1_addr_in  = s.rs1;
        bus.id_reg2_addr_in  = s.rs2;
        bus.id_reg1_re_in    = s.re1;
        bus.id_reg2_re_in    = s.re2;
        bus.ext_hold_req_in  = s.ext;
    endtask
    // Mode 0 run, 1 flushing, 2 waiting on busy, 3 external hold; m_left = flush cycles still owed
    task automatic predict(input stim_t s, output obs_t e);
        bit lu, run_rules;
        e    = '0;
        e.st = 2'(m_mode);
        e.sc = m_stalls;
        if (s.rst) begin
            e = '0;
            m_mode = 0;
            m_left = 0;
            m_stalls = 32'd0;
            return;
        end
        lu = s.load && s.rd != 5'd0 && ((s.re1 && s.rs1 == s.rd) || (s.re2 && s.rs2 == s.rd));
        run_rules = (m_mode == 0) || (m_mode == 2 && !s.busy) || (m_mode == 3 && (s.jump || !s.ext));
        if (m_mode == 1) begin
            e.if_flush = 1; e.id_flush = 1;
            m_left--;
            if (m_left == 0) m_mode = 0;
        end else if (!run_rules) begin
            e.pc_hold = 1; e.if_hold = 1; e.id_hold = 1;
        end else if (s.jump) begin
            e.jf = 1; e.ja = s.addr; e.if_flush = 1; e.id_flush = 1;
            m_left = DEPTH - 1;
            m_mode = (m_left > 0) ? 1 : 0;
        end else if (s.busy) begin
            e.pc_hold = 1; e.if_hold = 1; e.id_hold = 1;
            m_mode = 2;
        end else if (lu) begin
            e.pc_hold = 1; e.if_hold = 1; e.id_flush = 1;
            m_mode = 0;
        end else if (s.ext) begin
            e.pc_hold = 1; e.if_hold = 1; e.id_hold = 1;
            m_mode = 3;
        end else begin
            m_mode = 0;
        end
        if (e.pc_hold) m_stalls = m_stalls + 32'd1;
    endtask
    task automatic step(input stim_t s, input bit preload = 1'b0);
        obs_t e;
        @(negedge clk);
        if (preload) begin
            force dut.r_stall_cnt = 32'hFFFF_FFFE;
            #1;
            release dut.r_stall_cnt;
            m_stalls = 32'hFFFF_FFFE;
        end
        apply(s);
        #1;
        predict(s, e);
        exp_q.push_back(e);
        tag_q.push_back(phase);
    endtask
    initial begin : monitor
        obs_t  e, a;
        string t;
        forever begin
            @(negedge clk);
            #3;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                a = {bus.ctrl_jump_flag_out, bus.ctrl_jump_addr_out, bus.ctrl_pc_hold_out,
                     bus.ctrl_ifd_hold_out, bus.ctrl_ifd_flush_out, bus.ctrl_idd_hold_out,
                     bus.ctrl_idd_flush_out, bus.ctrl_state_out, bus.ctrl_stall_cnt_out};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL %s @%0t: got jf=%0b ja=%h pch=%0b ifh=%0b iff=%0b idh=%0b idf=%0b st=%0d sc=%h, expected jf=%0b ja=%h pch=%0b ifh=%0b iff=%0b idh=%0b idf=%0b st=%0d sc=%h",
                             t, $time, a.jf, a.ja, a.pc_hold, a.if_hold, a.if_flush, a.id_hold, a.id_flush, a.st, a.sc,
                             e.jf, e.ja, e.pc_hold, e.if_hold, e.if_flush, e.id_hold, e.id_flush, e.st, e.sc);
                end
            end
        end
    end
    initial begin : stimulus
        stim_t s;
        int busy_left, ext_left, wait_cnt;
        s = '0;
        s.rst = 1;
        apply(s);
        repeat (2) step(s);
        s = '0;
        phase = "idle";
        repeat (3) step(s);
        phase = "jump";
        s.jump = 1; s.addr = 32'h100;
        step(s);
        s = '0;
        repeat (3) step(s);
        phase = "loaduse";
        s.load = 1; s.rd = 5'd5; s.rs2 = 5'd5; s.re2 = 1;
        step(s);
        s = '0;
        step(s);
        phase = "loaduse_rd0";
        s.load = 1; s.rd = 5'd0; s.rs2 = 5'd0; s.re2 = 1;
        step(s);
        phase = "loaduse_re0";
        s.rd = 5'd5; s.rs2 = 5'd5; s.re2 = 0;
        step(s);
        phase = "busy4";
        s = '0; s.busy = 1;
        repeat (4) step(s);
        s = '0;
        repeat (2) step(s);
        phase = "jump_busy";
        s.jump = 1; s.busy = 1; s.addr = 32'hDEAD_BEE0;
        step(s);
        s.jump = 0;
        step(s);
        s = '0;
        repeat (2) step(s);
        phase = "flush_ignore";
        s.jump = 1; s.addr = 32'h0000_2000;
        step(s);
        s.addr = 32'h0000_3000; s.load = 1; s.rd = 5'd7; s.rs1 = 5'd7; s.re1 = 1;
        step(s);
        s = '0;
        repeat (2) step(s);
        phase = "rst_in_busy";
        s.busy = 1;
        repeat (2) step(s);
        s.rst = 1;
        step(s);
        s = '0;
        repeat (2) step(s);
        phase = "ext_hold";
        s.ext = 1;
        repeat (3) step(s);
        s.jump = 1; s.addr = 32'h0000_4440;
        step(s);
        s = '0;
        repeat (3) step(s);
        phase = "stall_wrap";
        step(s, 1'b1);
        s.busy = 1;
        repeat (3) step(s);
        s = '0;
        repeat (2) step(s);
        phase = "random";
        busy_left = 0;
        ext_left = 0;
        for (int i = 0; i < 400; i++) begin
            s = '0;
            s.rst  = ($urandom_range(0, 99) == 0);
            s.jump = ($urandom_range(0, 7) == 0);
            s.addr = $urandom;
            s.load = 1'($urandom_range(0, 1));
            s.rd   = 5'($urandom_range(0, 3));
            s.rs1  = 5'($urandom_range(0, 3));
            s.rs2  = 5'($urandom_range(0, 3));
            s.re1  = 1'($urandom_range(0, 1));
            s.re2  = 1'($urandom_range(0, 1));
            if (busy_left > 0) busy_left--;
            else if ($urandom_range(0, 9) == 0) busy_left = $urandom_range(1, 5);
            if (ext_left > 0) ext_left--;
            else if ($urandom_range(0, 11) == 0) ext_left = $urandom_range(1, 4);
            s.busy = (busy_left > 0);
            s.ext  = (ext_left > 0);
            step(s);
        end
        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 10) begin
            @(negedge clk);
            wait_cnt++;
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the 5-stage core. It takes jump requests from execute, load-use hazards between decode and execute, multi-cycle busy from execute, and external hold requests. It then drives hold/flush to the PC register, the IF/ID register (`instr_fetch_delay`) and the ID/EX register (`instr_decode_delay`). A sequencing FSM enforces post-jump bubble depth and multi-cycle waits, and keeps a stall-cycle counter.

## Interface
- `FLUSH_DEPTH`, default 2: bubble cycles after a taken jump, counting the jump cycle. Legal range 1–7.
- `clk`  in  1  core clock
- `rst`  in  1  synchronous, active-high reset
- `ex_jump_flag_in`  in  1  execute resolved a taken jump/branch
- `ex_jump_addr_in`  in  32  jump target
- `ex_load_flag_in`  in  1  instruction in EX is a load
- `ex_write_addr_in`  in  5  rd of instruction in EX
- `ex_busy_in`  in  1  multi-cycle unit (div) busy
- `id_reg1_addr_in`, `id_reg2_addr_in`  in  5 each  rs1/rs2 of instruction in ID
- `id_reg1_re_in`, `id_reg2_re_in`  in  1 each  rs1/rs2 actually read
- `ext_hold_req_in`  in  1  bus/debug hold request
- `ctrl_jump_flag_out`  out  1  PC redirect
- `ctrl_jump_addr_out`  out  32  redirect target
- `ctrl_pc_hold_out`  out  1  freeze PC
- `ctrl_ifd_hold_out`, `ctrl_ifd_flush_out`  out  1 each  IF/ID hold / load NOP
- `ctrl_idd_hold_out`, `ctrl_idd_flush_out`  out  1 each  ID/EX hold / load NOP (drives `idd_jump_flag_in`)
- `ctrl_state_out`  out  2  current FSM state
- `ctrl_stall_cnt_out`  out  32  cycles with `ctrl_pc_hold_out`=1

## Operation
- States: RUN=0, FLUSH=1, BUSY=2, EXT_HOLD=3. Reset → RUN, flush counter 0, stall count 0.
- Outputs are combinational from state + inputs. When no condition applies, all outputs are 0, and `ctrl_jump_addr_out`=0 unless `ctrl_jump_flag_out`=1.
- RUN priority, highest first:
  - jump: `ctrl_jump_flag_out`=1, `ctrl_jump_addr_out`=`ex_jump_addr_in`, `ctrl_ifd_flush_out`=`ctrl_idd_flush_out`=1. Next state is FLUSH with counter=`FLUSH_DEPTH`-1 if `FLUSH_DEPTH`>1, else RUN.
  - busy: `ctrl_pc_hold_out`=`ctrl_ifd_hold_out`=`ctrl_idd_hold_out`=1. Next state BUSY.
  - load-use: the condition is `ex_load_flag_in` && `ex_write_addr_in`≠0 && ((`id_reg1_re_in` && rs1==rd) || (`id_reg2_re_in` && rs2==rd)). Response: `ctrl_pc_hold_out`=`ctrl_ifd_hold_out`=1 and `ctrl_idd_flush_out`=1 (one bubble). State stays RUN; no state is kept for this case.
  - ext hold: pc/ifd/idd hold=1. Next state EXT_HOLD.
- FLUSH: `ctrl_ifd_flush_out`=`ctrl_idd_flush_out`=1. Counter decrements each cycle; go to RUN when the counter reaches 1→0. `ex_jump_flag_in`, `ex_busy_in` and the load-use condition are ignored because EX holds a bubble.
- BUSY: pc/ifd/idd hold=1 while `ex_busy_in`=1.
  - When `ex_busy_in`=0, the state returns to RUN at the next edge. That cycle already evaluates RUN priorities (Mealy exit).
  - A jump arriving with busy=0 in BUSY is handled exactly as in RUN.
- EXT_HOLD: pc/ifd/idd hold=1 until `ext_hold_req_in`=0, then RUN, same exit rule as BUSY. `ex_jump_flag_in` has priority: redirect plus flush, then FLUSH.
- Hold and flush on the same register are never both 1. Where both would apply, flush wins.
- Stall counter increments on every cycle with `ctrl_pc_hold_out`=1 and wraps 0xFFFFFFFF→0.

## Timing
- Jump → redirect and flush in the same cycle (zero latency). Flush stays asserted for exactly `FLUSH_DEPTH` consecutive cycles.
- Load-use → exactly 1 stall cycle. The next cycle the dependency has moved to MEM, so the condition drops.
- Busy asserted N cycles → N hold cycles. The hold drops combinationally in the cycle busy drops.
- Reset mid-FLUSH/BUSY → RUN next edge. All outputs are 0 during the reset cycle and the counter clears.
- `ctrl_stall_cnt_out` is registered, so it updates one cycle after the hold cycle.

## Structure
- Shared package/defines: state encodings `CTRL_RUN`/`CTRL_FLUSH`/`CTRL_BUSY`/`CTRL_EXT_HOLD`, and `ZERO_REG` (5'b0).
- One sub-module, `hazard_detect`: purely combinational load-use compare. The FSM, flush counter and stall counter live in the top module.

## Test plan
- Jump at cycle 10, addr 0x100, `FLUSH_DEPTH`=2 → jump_flag=1 and addr=0x100 in cycle 10; ifd/idd flush=1 in cycles 10–11; state RUN at cycle 12.
- EX load rd=5, ID rs2=5 with re2=1 → one cycle of pc/ifd hold=1 and idd_flush=1. Same with rd=0, or with re2=0 → no stall.
- `ex_busy_in` high for 4 cycles → 4 cycles of pc/ifd/idd hold; state BUSY; stall count +4.
- Jump and busy in the same RUN cycle → jump wins, busy ignored for the flush window.
- In FLUSH, assert a load-use match and `ex_jump_flag_in` → both ignored and the flush count is unchanged. `rst` asserted mid-BUSY → next cycle state=0 and counter=0.
- Preload counter near wrap by forcing 0xFFFFFFFE, then stall 3 cycles → reads 0x00000001.
